// File: rtl/dsp_pkg.sv
// dsp_pkg: shared constants and helpers for the sail-core add/subtract datapath.
//   LANE_W       - width of one adder lane (one SB_MAC16 adder half)
//   MAX_W        - widest operand the helpers support
//   OP_ADD/OP_SUB - in_op encodings
//   sat_max/min  - signed saturation limits of a given width, zero-extended to MAX_W
package dsp_pkg;

    localparam int LANE_W = 16;
    localparam int MAX_W  = 128;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Largest signed value representable in w bits: 0111...1
    function automatic logic [MAX_W-1:0] sat_max(input int w);
        logic [MAX_W-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return (one << (w - 1)) - one;
    endfunction

    // Smallest signed value representable in w bits: 1000...0
    function automatic logic [MAX_W-1:0] sat_min(input int w);
        logic [MAX_W-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << (w - 1);
    endfunction

endpackage

// File: rtl/dsp_lane_add.sv
// dsp_lane_add: one registered 16-bit adder lane with carry-in.
//   clk, rst_n      - clock, synchronous active-low reset
//   en              - pipeline advance; when low every register holds
//   vin             - valid of the beat presented on a/b/cin
//   a, b, cin       - lane operands (b already conditioned for subtract)
//   sum_q, cout_q   - registered lane sum and carry-out
//   vout_q          - registered valid travelling with the sum
module dsp_lane_add
    import dsp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              vin,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              cin,
    output logic [LANE_W-1:0] sum_q,
    output logic              cout_q,
    output logic              vout_q
);

    logic [LANE_W:0]   add_s;
    logic [LANE_W-1:0] sum_d;
    logic              cout_d;
    logic              vout_d;

    // Lane add and hold-or-load selection for the lane registers
    always_comb begin
        add_s = {1'b0, a} + {1'b0, b} + {{LANE_W{1'b0}}, cin};
        if (en) begin
            sum_d  = add_s[LANE_W-1:0];
            cout_d = add_s[LANE_W];
            vout_d = vin;
        end else begin
            sum_d  = sum_q;
            cout_d = cout_q;
            vout_d = vout_q;
        end
    end

    // Lane registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            vout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            vout_q <= vout_d;
        end
    end

endmodule

// File: rtl/dsp_addsub_pipe.sv
// dsp_addsub_pipe: pipelined WIDTH-bit add/subtract, one 16-bit lane per stage,
// followed by a registered output stage holding flags and optional saturation.
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - operand handshake (in_ready = global advance)
//   in_a, in_b, in_op     - operands, 0 = A+B, 1 = A-B
//   out_valid/out_ready   - result handshake with backpressure
//   out_sum               - result (wrapped, or clamped when SATURATE = 1)
//   out_cout              - carry-out for add, not-borrow for subtract
//   out_ovf               - signed overflow of the true result
module dsp_addsub_pipe
    import dsp_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LANES = WIDTH / LANE_W;
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

    logic              adv_s;
    logic [WIDTH-1:0]  bp_s;
    logic              cin0_s;
    logic [LANE_W-1:0] lane_a_s   [LANES];
    logic [LANE_W-1:0] lane_b_s   [LANES];
    logic [LANE_W-1:0] lane_sum_s [LANES];
    logic [LANES-1:0]  lane_cin_s;
    logic [LANES-1:0]  lane_vin_s;
    logic [LANES-1:0]  lane_c_s;
    logic [LANES-1:0]  lane_v_s;
    logic              a_msb_d, a_msb_q;
    logic              b_msb_d, b_msb_q;
    logic [WIDTH-1:0]  raw_sum_s;
    logic [WIDTH-1:0]  sat_sum_s;
    logic              ovf_s;
    logic              out_valid_d, out_valid_q;
    logic [WIDTH-1:0]  out_sum_d, out_sum_q;
    logic              out_cout_d, out_cout_q;
    logic              out_ovf_d, out_ovf_q;

    // The whole pipeline moves as one: it stalls only when a result is stuck at the output
    assign adv_s     = !out_valid_q || out_ready;
    assign in_ready  = adv_s;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

    // Subtract is A + ~B + 1: invert B and inject the +1 as lane-0 carry-in
    always_comb begin
        case (in_op)
            OP_ADD: begin
                bp_s   = in_b;
                cin0_s = 1'b0;
            end
            OP_SUB: begin
                bp_s   = ~in_b;
                cin0_s = 1'b1;
            end
            default: begin
                bp_s   = in_b;
                cin0_s = 1'b0;
            end
        endcase
    end

    for (genvar k = 0; k < LANES; k++) begin : g_stage
        // Operand lanes k..LANES-1 as seen by stage k (lower lanes already consumed)
        logic [(LANES-k)*LANE_W-1:0] rem_a_s;
        logic [(LANES-k)*LANE_W-1:0] rem_b_s;

        if (k == 0) begin : g_src
            assign rem_a_s       = in_a;
            assign rem_b_s       = bp_s;
            assign lane_cin_s[k] = cin0_s;
            assign lane_vin_s[k] = in_valid;
        end else begin : g_src
            assign rem_a_s       = g_stage[k-1].g_up.up_a_q;
            assign rem_b_s       = g_stage[k-1].g_up.up_b_q;
            assign lane_cin_s[k] = lane_c_s[k-1];
            assign lane_vin_s[k] = lane_v_s[k-1];
        end

        assign lane_a_s[k] = rem_a_s[LANE_W-1:0];
        assign lane_b_s[k] = rem_b_s[LANE_W-1:0];

        dsp_lane_add u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (adv_s),
            .vin    (lane_vin_s[k]),
            .a      (lane_a_s[k]),
            .b      (lane_b_s[k]),
            .cin    (lane_cin_s[k]),
            .sum_q  (lane_sum_s[k]),
            .cout_q (lane_c_s[k]),
            .vout_q (lane_v_s[k])
        );

        // Skew: upper operand lanes wait here until their carry is ready
        if (k < LANES - 1) begin : g_up
            logic [(LANES-k-1)*LANE_W-1:0] up_a_d, up_a_q;
            logic [(LANES-k-1)*LANE_W-1:0] up_b_d, up_b_q;

            // Load the not-yet-added lanes or hold on stall
            always_comb begin
                if (adv_s) begin
                    up_a_d = rem_a_s[(LANES-k)*LANE_W-1:LANE_W];
                    up_b_d = rem_b_s[(LANES-k)*LANE_W-1:LANE_W];
                end else begin
                    up_a_d = up_a_q;
                    up_b_d = up_b_q;
                end
            end

            // Skew registers
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    up_a_q <= '0;
                    up_b_q <= '0;
                end else begin
                    up_a_q <= up_a_d;
                    up_b_q <= up_b_d;
                end
            end
        end

        // Deskew: finished lower sum lanes ride alongside lane k's sum
        if (k > 0) begin : g_lo
            logic [k*LANE_W-1:0] lo_src_s;
            logic [k*LANE_W-1:0] lo_d, lo_q;

            if (k == 1) begin : g_cat
                assign lo_src_s = lane_sum_s[0];
            end else begin : g_cat
                assign lo_src_s = {lane_sum_s[k-1], g_stage[k-1].g_lo.lo_q};
            end

            // Load the completed lower lanes or hold on stall
            always_comb begin
                if (adv_s) begin
                    lo_d = lo_src_s;
                end else begin
                    lo_d = lo_q;
                end
            end

            // Deskew registers
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lo_q <= '0;
                end else begin
                    lo_q <= lo_d;
                end
            end
        end
    end

    if (LANES == 1) begin : g_res
        assign raw_sum_s = lane_sum_s[0];
    end else begin : g_res
        assign raw_sum_s = {lane_sum_s[LANES-1], g_stage[LANES-1].g_lo.lo_q};
    end

    // Operand sign bits captured with the top lane, needed for the overflow test
    always_comb begin
        if (adv_s) begin
            a_msb_d = lane_a_s[LANES-1][LANE_W-1];
            b_msb_d = lane_b_s[LANES-1][LANE_W-1];
        end else begin
            a_msb_d = a_msb_q;
            b_msb_d = b_msb_q;
        end
    end

    // Sign-bit registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    // Overflow: same-sign operands producing a different-sign result; clamp toward A's sign
    always_comb begin
        ovf_s = (a_msb_q == b_msb_q) && (raw_sum_s[WIDTH-1] != a_msb_q);
        if (SATURATE && ovf_s) begin
            sat_sum_s = a_msb_q ? SMIN : SMAX;
        end else begin
            sat_sum_s = raw_sum_s;
        end
        if (adv_s) begin
            out_valid_d = lane_v_s[LANES-1];
            out_sum_d   = sat_sum_s;
            out_cout_d  = lane_c_s[LANES-1];
            out_ovf_d   = ovf_s;
        end else begin
            out_valid_d = out_valid_q;
            out_sum_d   = out_sum_q;
            out_cout_d  = out_cout_q;
            out_ovf_d   = out_ovf_q;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule
